// File: rtl/rst_seq.sv
`timescale 1ns/1ps
// rst_seq: reset sequencer. Merges a board push-button and a USB-controller reset
//   into one sequenced active-low reset (ASSERT -> HOLD -> RUN), with cause and event count.
// Latency: raw SL_RST_N fall to RST_OUT_N low is 3 SYS_CLK cycles; release needs 1 + HOLD_CYCLES quiet cycles.
// Backpressure: none; level-driven inputs, all outputs registered.
//
// Ports:
//   SYS_CLK      in   single clock for all logic
//   SYS_RST_N    in   async active-low reset (clock-manager lock)
//   BOARD_RST_SW in   raw board push-button, active-high, async to SYS_CLK
//   SL_RST_N     in   raw USB-controller reset, active-low, async to SYS_CLK
//   RST_OUT_N    out  sequenced active-low reset, straight from a flop
//   RST_CAUSE    out  source of last reset: bit1 SL_RST_N, bit0 board switch
//   RST_COUNT    out  reset events since SYS_RST_N, saturates at 255
//   BUSY         out  high while not in RUN
//
// Optional feature: define RST_SEQ_DEBOUNCE_EN to debounce the board switch for
// SYS_CLK_FREQ/1_000_000*DEBOUNCE_US cycles. Without it the switch is used as soon
// as it is synchronized and no debounce counter exists. SL_RST_N is never debounced.

module rst_seq #(
    parameter int unsigned SYS_CLK_FREQ = 80_000_000,
    parameter int unsigned DEBOUNCE_US  = 10,
    parameter int unsigned HOLD_CYCLES  = 16
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       BOARD_RST_SW,
    input  logic       SL_RST_N,
    output logic       RST_OUT_N,
    output logic [1:0] RST_CAUSE,
    output logic [7:0] RST_COUNT,
    output logic       BUSY
);

    localparam int unsigned DEBOUNCE_CYCLES = SYS_CLK_FREQ / 1_000_000 * DEBOUNCE_US;
    localparam logic [15:0] HOLD_LAST       = 16'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("rst_seq: HOLD_CYCLES must be in 1..65535");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("rst_seq: debounce window must be at least one cycle");
    end

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // 2-flop synchronizers, reset to the inactive level of each source
    // ------------------------------------------------------------------
    logic sw_s1_q, sw_s2_q;
    logic sl_s1_q, sl_s2_q;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            sw_s1_q <= 1'b0;
            sw_s2_q <= 1'b0;
            sl_s1_q <= 1'b1;
            sl_s2_q <= 1'b1;
        end else begin
            sw_s1_q <= BOARD_RST_SW;
            sw_s2_q <= sw_s1_q;
            sl_s1_q <= SL_RST_N;
            sl_s2_q <= sl_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Board-switch qualification
    // ------------------------------------------------------------------
    logic sw_qual;

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int unsigned DB_LAST = DEBOUNCE_CYCLES - 1;
    localparam int          DB_W    = $clog2(DB_LAST + 2);

    logic [DB_W-1:0] db_cnt_q;
    logic            sw_qual_q;

    // Count consecutive cycles in which the synchronized switch differs from
    // the qualified level. Any return to the qualified level (a bounce)
    // clears the count, so only an unbroken run flips the qualified level.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            db_cnt_q  <= '0;
            sw_qual_q <= 1'b0;
        end else if (sw_s2_q == sw_qual_q) begin
            db_cnt_q  <= '0;
        end else if (db_cnt_q == DB_W'(DB_LAST)) begin
            db_cnt_q  <= '0;
            sw_qual_q <= sw_s2_q;
        end else begin
            db_cnt_q  <= db_cnt_q + 1'b1;
        end
    end

    assign sw_qual = sw_qual_q;
`else
    assign sw_qual = sw_s2_q;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    logic       req;
    logic [1:0] cause_d;

    assign req     = ~sl_s2_q | sw_qual;
    assign cause_d = {~sl_s2_q, sw_qual};

    state_t      state_q;
    logic [15:0] hold_cnt_q;
    logic        rst_out_q;
    logic        busy_q;
    logic [1:0]  cause_q;
    logic [7:0]  count_q;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= '0;
            rst_out_q  <= 1'b0;
            busy_q     <= 1'b1;
            cause_q    <= 2'b00;
            count_q    <= 8'd0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rst_out_q <= 1'b0;
                    busy_q    <= 1'b1;
                    if (!req) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (req) begin
                        // Abort the run-up; the reset output was never released.
                        state_q <= ST_ASSERT;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q   <= ST_RUN;
                        rst_out_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (req) begin
                        state_q   <= ST_ASSERT;
                        rst_out_q <= 1'b0;
                        busy_q    <= 1'b1;
                        cause_q   <= cause_d;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_ASSERT;
                    rst_out_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign RST_OUT_N = rst_out_q;
    assign BUSY      = busy_q;
    assign RST_CAUSE = cause_q;
    assign RST_COUNT = count_q;

endmodule
